alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Registered integer ALU for the Lab 6 integer datapath.
- Sits directly downstream of the S-operand select mux. It consumes R from the register file and S from the mux (register S or external DS).
- Produces a registered result Y and N/Z/C status flags. Y is written back to the register file.
- Single-cycle ops complete in 1 clock. A 16x16 unsigned multiply runs as a 16-cycle sequential shift-add.

Parameters:
- W, 16, operand/result width. Multiply iteration count equals W.

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  operation request, sampled on rising clk when busy=0
- Alu_Op  input  4  operation code, sampled with start
- R  input  W  operand R (register file)
- S  input  W  operand S (S-mux output)
- Y  output  W  registered result (low word for MUL)
- Y_hi  output  W  registered high word of MUL product; 0 for all other ops
- N  output  1  negative flag
- Z  output  1  zero flag
- C  output  1  carry / borrow / shift-out / MUL-overflow flag
- busy  output  1  high while MUL iterates
- done  output  1  one-cycle pulse when Y/flags update

Behaviour:
- Reset (reset_n=0, asynchronous): Y=0, Y_hi=0, N=0, Z=0, C=0, busy=0, done=0, state=IDLE, iteration counter=0. Reset mid-MUL aborts the operation with no done.
- States: IDLE, MUL.
  - IDLE, start=1, op≠MUL: compute, register Y/Y_hi/flags, done=1 for one cycle (latency 1). Stay in IDLE.
  - IDLE, start=1, op=MUL: latch R and S, clear the accumulator, counter=0, busy=1, go to MUL.
  - MUL: one shift-add step per clock. On the 16th step, write {Y_hi,Y}=R*S, busy=0, done=1, return to IDLE. Done is seen 16 clocks after the start edge.
- start while busy=1 is ignored. It is not queued, and the in-flight MUL is unaffected.
- Y and flags hold their values between operations. done is 0 in every cycle not listed above.
- Opcodes (arithmetic is modulo 2^W, unsigned carry):
  - 0: Y=R, C=0
  - 1: Y=S, C=0
  - 2: Y=R+S, C=carry out
  - 3: Y=R-S, C=1 iff R>=S unsigned (no borrow)
  - 4: Y=S-R, C=1 iff S>=R
  - 5: Y=R&S, C=0
  - 6: Y=R|S, C=0
  - 7: Y=R^S, C=0
  - 8: Y=~S, C=0
  - 9: Y=S+1, C=carry out
  - 10: Y=S-1, C=1 iff S≠0
  - 11: Y=S<<1, C=S[15]
  - 12: Y=S>>1 logical, C=S[0]
  - 13: Y=S>>>1 arithmetic, C=S[0]
  - 14: MUL, {Y_hi,Y}=R*S unsigned, C=1 iff Y_hi≠0
  - 15: reserved, Y=0, C=0
- Flags for non-MUL ops: N=Y[15], Z=(Y==0), Y_hi=0.
- Flags for MUL: N=Y_hi[15], Z=({Y_hi,Y}==0).
- Operand inputs R/S may change during MUL with no effect, because operands are latched at start.
- back-to-back: start high in consecutive IDLE cycles gives one result per clock, with done high continuously.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, no done until start.
- ADD: R=0xFFFF, S=0x0001, op=2, start -> next cycle Y=0x0000, Z=1, C=1, N=0, done=1 for exactly one cycle.
- SUB: R=0x0003, S=0x0005, op=3 -> Y=0xFFFE, N=1, Z=0, C=0. Then op=4 -> Y=0x0002, C=1.
- Shifts:
  - S=0x0001, op=12 -> Y=0, Z=1, C=1.
  - S=0x8000, op=13 -> Y=0xC000, N=1, C=0.
  - S=0x8000, op=11 -> Y=0, C=1.
- MUL: R=0x1234, S=0x0010, op=14 -> busy=1 for 16 cycles. start/op=2 pulsed during busy is ignored. Then Y=0x2340, Y_hi=0x0001, C=1, done once. Also R=0xFFFF, S=0xFFFF -> Y_hi=0xFFFE, Y=0x0001, N=1.
- Reset mid-MUL: assert reset_n=0 at iteration 8 -> busy=0, no done. After release, a new op=1 with S=0x00AA gives Y=0x00AA, latency 1.

Source files
------------

// File: rtl/alu_stage.sv
// Registered integer ALU: single-cycle logic/arith/shift ops plus a W-cycle
// sequential shift-add unsigned multiply producing a 2W-bit product.
module alu_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   Alu_Op,
    input  logic [W-1:0] R,
    input  logic [W-1:0] S,
    output logic [W-1:0] Y,
    output logic [W-1:0] Y_hi,
    output logic         N,
    output logic         Z,
    output logic         C,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [3:0] OP_MUL = 4'd14;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   y_q, y_d, yhi_q, yhi_d;
    logic           n_q, n_d, z_q, z_d, c_q, c_d, done_q, done_d;

    logic [W-1:0]   alu_y;
    logic           alu_c;
    logic [W:0]     ext;
    logic [W:0]     sum;
    logic [2*W-1:0] step;

    // Single-cycle datapath; ext carries the extra bit for carry/borrow.
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        ext   = '0;
        unique case (Alu_Op)
            4'd0:  alu_y = R;
            4'd1:  alu_y = S;
            4'd2:  begin ext = {1'b0, R} + {1'b0, S}; alu_y = ext[W-1:0]; alu_c = ext[W]; end
            4'd3:  begin ext = {1'b0, R} - {1'b0, S}; alu_y = ext[W-1:0]; alu_c = ~ext[W]; end
            4'd4:  begin ext = {1'b0, S} - {1'b0, R}; alu_y = ext[W-1:0]; alu_c = ~ext[W]; end
            4'd5:  alu_y = R & S;
            4'd6:  alu_y = R | S;
            4'd7:  alu_y = R ^ S;
            4'd8:  alu_y = ~S;
            4'd9:  begin ext = {1'b0, S} + (W+1)'(1); alu_y = ext[W-1:0]; alu_c = ext[W]; end
            4'd10: begin alu_y = S - W'(1); alu_c = |S; end
            4'd11: begin alu_y = {S[W-2:0], 1'b0}; alu_c = S[W-1]; end
            4'd12: begin alu_y = {1'b0, S[W-1:1]}; alu_c = S[0]; end
            4'd13: begin alu_y = {S[W-1], S[W-1:1]}; alu_c = S[0]; end
            default: ;
        endcase
    end

    // acc holds {partial high word, remaining multiplier bits}; each step
    // conditionally adds the multiplicand to the high half, then shifts right.
    always_comb begin
        sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step = {sum, acc_q[W-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        y_d     = y_q;
        yhi_d   = yhi_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (Alu_Op == OP_MUL) begin
                        mcand_d = R;
                        acc_d   = {{W{1'b0}}, S};
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        y_d    = alu_y;
                        yhi_d  = '0;
                        n_d    = alu_y[W-1];
                        z_d    = (alu_y == '0);
                        c_d    = alu_c;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    y_d     = step[W-1:0];
                    yhi_d   = step[2*W-1:W];
                    n_d     = step[2*W-1];
                    z_d     = (step == '0);
                    c_d     = |step[2*W-1:W];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            yhi_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            yhi_q   <= yhi_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign Y    = y_q;
    assign Y_hi = yhi_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign C    = c_q;
    assign done = done_q;
    assign busy = (state_q == MUL);

endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: vector table for single-cycle ops plus
// hand-written multiply, ignored-start and reset corner sequences.
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  Alu_Op = '0;
    logic [15:0] R = '0, S = '0;
    logic [15:0] Y, Y_hi;
    logic        N, Z, C, busy, done;

    int checks = 0;
    int failures = 0;

    alu_stage #(.W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .Alu_Op(Alu_Op),
        .R(R), .S(S), .Y(Y), .Y_hi(Y_hi), .N(N), .Z(Z), .C(C),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] r, s, y;
        logic        n, z, c;
    } vec_t;

    vec_t tbl[20];

    // packed view: {Y, Y_hi, N, Z, C, busy, done}
    task automatic chk(input string nm, input logic [36:0] got, input logic [36:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got Y=%h Yhi=%h NZC=%b busy=%b done=%b want Y=%h Yhi=%h NZC=%b busy=%b done=%b",
                     nm, got[36:21], got[20:5], got[4:2], got[1], got[0],
                     exp[36:21], exp[20:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [36:0] outs();
        return {Y, Y_hi, N, Z, C, busy, done};
    endfunction

    task automatic drive(input logic st, input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
        @(negedge clk);
        start = st; Alu_Op = op; R = r; S = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input string nm, input logic [15:0] r, input logic [15:0] s,
                           input logic [15:0] ey, input logic [15:0] ehi,
                           input logic en, input logic ez, input logic ec);
        logic [15:0] y0, h0;
        logic [2:0]  f0;
        y0 = Y; h0 = Y_hi; f0 = {N, Z, C};
        drive(1'b1, 4'd14, r, s);
        tick();
        chk({nm, "_start"}, outs(), {y0, h0, f0, 1'b1, 1'b0});
        for (int i = 1; i <= 16; i++) begin
            // stray request mid-multiply, plus operand churn
            if (i == 5) drive(1'b1, 4'd2, 16'h1111, 16'h2222);
            else        drive(1'b0, 4'd0, 16'hDEAD ^ 16'(i), 16'hBEEF);
            tick();
            if (i < 16) chk({nm, "_iter"}, outs(), {y0, h0, f0, 1'b1, 1'b0});
            else        chk({nm, "_done"}, outs(), {ey, ehi, en, ez, ec, 1'b0, 1'b1});
        end
        drive(1'b0, 4'd0, 16'h0, 16'h0);
        tick();
        chk({nm, "_hold"}, outs(), {ey, ehi, en, ez, ec, 1'b0, 1'b0});
    endtask

    initial begin
        tbl[0]  = '{4'd0,  16'h1234, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  16'h1234, 16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd2,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{4'd2,  16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'd3,  16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'd4,  16'h0003, 16'h0005, 16'h0002, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{4'd3,  16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{4'd5,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'd6,  16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'd7,  16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'd8,  16'h0000, 16'h00FF, 16'hFF00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'd9,  16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{4'd10, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'd10, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{4'd11, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{4'd11, 16'h0000, 16'h4001, 16'h8002, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{4'd12, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{4'd13, 16'h0000, 16'h8000, 16'hC000, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{4'd13, 16'h0000, 16'h8001, 16'hC000, 1'b1, 1'b0, 1'b1};

        #2;
        chk("reset_state", outs(), 37'd0);
        drive(1'b0, 4'd0, 16'h0, 16'h0);
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_no_done", outs(), 37'd0);

        // back-to-back: start held high, one result and done per clock
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].r, tbl[i].s);
            tick();
            chk($sformatf("vec%0d_op%0d", i, tbl[i].op), outs(),
                {tbl[i].y, 16'h0, tbl[i].n, tbl[i].z, tbl[i].c, 1'b0, 1'b1});
        end
        drive(1'b0, 4'd2, 16'h1, 16'h1);
        tick();
        chk("hold_after_table", outs(), {16'hC000, 16'h0, 3'b101, 1'b0, 1'b0});

        run_mul("mul_1234x10", 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 1'b0, 1'b1);
        run_mul("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b1);
        run_mul("mul_zero", 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        // single op after MUL must clear Y_hi
        drive(1'b1, 4'd1, 16'h0, 16'h7FFF);
        tick();
        chk("op_after_mul", outs(), {16'h7FFF, 16'h0, 3'b000, 1'b0, 1'b1});

        // asynchronous reset in the middle of a multiply
        run_mul("mul_pre", 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd14, 16'h1234, 16'h5678);
        tick();
        drive(1'b0, 4'd0, 16'h0, 16'h0);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_mul_busy", outs(), {16'hFFFF, 16'h0, 3'b000, 1'b1, 1'b0});
        #2 reset_n = 1'b0;
        #1 chk("async_reset", outs(), 37'd0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) begin
                chk("no_done_after_abort", outs(), 37'd0);
                break;
            end
        end
        chk("post_abort_idle", outs(), 37'd0);
        drive(1'b1, 4'd1, 16'h0, 16'h00AA);
        tick();
        chk("post_reset_op1", outs(), {16'h00AA, 16'h0, 3'b000, 1'b0, 1'b1});
        drive(1'b0, 4'd0, 16'h0, 16'h0);
        tick();
        chk("post_reset_done_pulse", outs(), {16'h00AA, 16'h0, 3'b000, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
